// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// datapath select values, ALU ops, FSM states and instruction classes.
package mips_ctrl_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluXor = 3'd2,
        AluSlt = 3'd3
    } alu_op_e;

    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcBranch = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;
    localparam logic [1:0] PcSrcRs     = 2'd3;

    localparam logic [1:0] RegDstRt = 2'd0;
    localparam logic [1:0] RegDstRd = 2'd1;
    localparam logic [1:0] RegDstRa = 2'd2;

    localparam logic [1:0] MemToRegAlu = 2'd0;
    localparam logic [1:0] MemToRegMem = 2'd1;
    localparam logic [1:0] MemToRegPc4 = 2'd2;

    localparam logic [1:0] SrcBRt    = 2'd0;
    localparam logic [1:0] SrcBFour  = 2'd1;
    localparam logic [1:0] SrcBImm   = 2'd2;
    localparam logic [1:0] SrcBImmSh = 2'd3;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StAddr,
        StMemRd,
        StMemWr,
        StWbMem,
        StExecR,
        StExecI,
        StWbAlu,
        StBranch,
        StJump,
        StTrap
    } state_e;

    typedef enum logic [3:0] {
        ClsLoad,
        ClsStore,
        ClsAluR,
        ClsAluI,
        ClsBeq,
        ClsBne,
        ClsJ,
        ClsJal,
        ClsJr,
        ClsIllegal
    } instr_class_e;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control-unit <-> datapath bundle. The FSM side uses the slave modport,
// the datapath (or a bench) the master modport.
interface mc_control_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      instr;
    logic             alu_zero;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             iord;
    logic             alu_src_a;
    logic [1:0]       pc_src;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             illegal;
    logic             bus_error;
    logic [CNT_W-1:0] retired;

    modport master (
        output instr, alu_zero, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, reg_write, iord, alu_src_a,
        input  pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op,
        input  illegal, bus_error, retired
    );

    modport slave (
        input  instr, alu_zero, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, reg_write, iord, alu_src_a,
        output pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op,
        output illegal, bus_error, retired
    );

endinterface

// File: rtl/mc_control_fsm_instr_class.sv
// Combinational classifier: opcode/funct to instruction class, the ALU op the
// execute step needs, and a legal flag.
module instr_class
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   funct_i,
    output instr_class_e cls_o,
    output alu_op_e      alu_op_o,
    output logic         legal_o
);

    always_comb begin
        cls_o    = ClsIllegal;
        alu_op_o = AluAdd;
        case (opcode_i)
            OpRtype: begin
                case (funct_i)
                    FnJr:  cls_o = ClsJr;
                    FnAdd: cls_o = ClsAluR;
                    FnSub: begin
                        cls_o    = ClsAluR;
                        alu_op_o = AluSub;
                    end
                    FnSlt: begin
                        cls_o    = ClsAluR;
                        alu_op_o = AluSlt;
                    end
                    default: cls_o = ClsIllegal;
                endcase
            end
            OpLw:   cls_o = ClsLoad;
            OpSw:   cls_o = ClsStore;
            OpJ:    cls_o = ClsJ;
            OpJal:  cls_o = ClsJal;
            OpBeq: begin
                cls_o    = ClsBeq;
                alu_op_o = AluSub;
            end
            OpBne: begin
                cls_o    = ClsBne;
                alu_op_o = AluSub;
            end
            OpAddi: cls_o = ClsAluI;
            OpXori: begin
                cls_o    = ClsAluI;
                alu_op_o = AluXor;
            end
            default: cls_o = ClsIllegal;
        endcase
        legal_o = (cls_o != ClsIllegal);
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// waits on mem_ready with a timeout, traps on illegal opcodes, counts retirements.
module mc_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    mc_control_fsm_if.slave bus
);

    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    state_e           state_q;
    logic [7:0]       wait_q;
    logic [1:0]       wb_dst_q;
    logic             illegal_q;
    logic             bus_error_q;
    logic [CNT_W-1:0] retired_q;

    instr_class_e cls;
    alu_op_e      cls_alu_op;
    logic         instr_legal;
    logic         in_mem_wait;
    logic [7:0]   wait_inc;
    logic         timeout;
    logic         retire;

    instr_class u_instr_class (
        .opcode_i (bus.instr[31:26]),
        .funct_i  (bus.instr[5:0]),
        .cls_o    (cls),
        .alu_op_o (cls_alu_op),
        .legal_o  (instr_legal)
    );

    assign in_mem_wait = (state_q == StFetch || state_q == StMemRd || state_q == StMemWr)
                         && !bus.mem_ready;
    assign wait_inc    = wait_q + 8'd1;
    // A ready on the last allowed cycle beats the timeout since in_mem_wait is then low.
    assign timeout     = in_mem_wait && (wait_inc == TimeoutCnt);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StFetch;
            wait_q      <= 8'd0;
            wb_dst_q    <= RegDstRt;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            wait_q <= in_mem_wait ? wait_inc : 8'd0;
            if (retire) retired_q <= retired_q + CNT_W'(1);
            case (state_q)
                StFetch, StMemRd, StMemWr: begin
                    if (bus.mem_ready) begin
                        state_q <= (state_q == StFetch) ? StDecode :
                                   (state_q == StMemRd) ? StWbMem : StFetch;
                    end else if (timeout) begin
                        state_q     <= StTrap;
                        bus_error_q <= 1'b1;
                    end
                end
                StDecode: begin
                    if (!instr_legal) begin
                        state_q   <= StTrap;
                        illegal_q <= 1'b1;
                    end else begin
                        case (cls)
                            ClsLoad, ClsStore: state_q <= StAddr;
                            ClsAluR:           state_q <= StExecR;
                            ClsAluI:           state_q <= StExecI;
                            ClsBeq, ClsBne:    state_q <= StBranch;
                            default:           state_q <= StJump;
                        endcase
                    end
                end
                StAddr:  state_q <= (cls == ClsLoad) ? StMemRd : StMemWr;
                StExecR: begin
                    wb_dst_q <= RegDstRd;
                    state_q  <= StWbAlu;
                end
                StExecI: begin
                    wb_dst_q <= RegDstRt;
                    state_q  <= StWbAlu;
                end
                StWbMem, StWbAlu, StBranch, StJump: state_q <= StFetch;
                StTrap:  state_q <= StTrap;
                default: state_q <= StFetch;
            endcase
        end
    end

    // Outputs decode from state; reset forces everything idle so an aborted
    // instruction never writes.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.pc_src     = PcSrcAlu;
        bus.reg_dst    = RegDstRt;
        bus.mem_to_reg = MemToRegAlu;
        bus.alu_src_b  = SrcBRt;
        bus.alu_op     = AluAdd;
        retire         = 1'b0;
        if (!reset_i) begin
            case (state_q)
                StFetch: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SrcBFour;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                StDecode: bus.alu_src_b = SrcBImmSh;
                StAddr: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SrcBImm;
                end
                StMemRd: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                end
                StMemWr: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                    retire        = bus.mem_ready;
                end
                StWbMem: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = MemToRegMem;
                    retire         = 1'b1;
                end
                StExecR, StExecI: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = (state_q == StExecR) ? SrcBRt : SrcBImm;
                    bus.alu_op    = cls_alu_op;
                end
                StWbAlu: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = wb_dst_q;
                    retire        = 1'b1;
                end
                StBranch: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = AluSub;
                    bus.pc_src    = PcSrcBranch;
                    bus.pc_write  = (cls == ClsBeq) ? bus.alu_zero : !bus.alu_zero;
                    retire        = 1'b1;
                end
                StJump: begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = (cls == ClsJr) ? PcSrcRs : PcSrcJump;
                    if (cls == ClsJal) begin
                        bus.reg_write  = 1'b1;
                        bus.reg_dst    = RegDstRa;
                        bus.mem_to_reg = MemToRegPc4;
                    end
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.illegal   = illegal_q;
    assign bus.bus_error = bus_error_q;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomised bench for mc_control_fsm: an instruction-level model queues the
// expected per-cycle controls, a negedge monitor pops and compares them.
module tb_mc_control_fsm;

    localparam int T = 15;

    typedef logic [17:0] ctrl_t;
    typedef enum {KLw, KSw, KR, KI, KBeq, KBne, KJ, KJal, KJr, KIll} kind_e;
    typedef struct {
        ctrl_t       c;
        bit          chk;
        bit          ill;
        bit          be;
        logic [31:0] ret;
    } exp_t;

    localparam ctrl_t IDLE = '0;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mc_control_fsm_if #(.CNT_W(32)) bus ();

    mc_control_fsm #(
        .MEM_TIMEOUT (T),
        .CNT_W       (32)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    bit          m_ill;
    bit          m_be;
    logic [31:0] m_ret;

    // Order: pc_write ir_write mem_read mem_write reg_write iord alu_src_a
    //        pc_src reg_dst mem_to_reg alu_src_b alu_op
    function automatic ctrl_t mk(input bit pcw, input bit irw, input bit mrd, input bit mwr,
                                 input bit rw, input bit iord, input bit asa,
                                 input logic [1:0] pcs, input logic [1:0] rd,
                                 input logic [1:0] m2r, input logic [1:0] asb,
                                 input logic [2:0] op);
        return {pcw, irw, mrd, mwr, rw, iord, asa, pcs, rd, m2r, asb, op};
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic kind_e kind_of(input logic [31:0] ins);
        case (ins[31:26])
            6'h23: return KLw;
            6'h2B: return KSw;
            6'h02: return KJ;
            6'h03: return KJal;
            6'h04: return KBeq;
            6'h05: return KBne;
            6'h08, 6'h0E: return KI;
            6'h00: begin
                case (ins[5:0])
                    6'h08: return KJr;
                    6'h20, 6'h22, 6'h2A: return KR;
                    default: return KIll;
                endcase
            end
            default: return KIll;
        endcase
    endfunction

    function automatic logic [2:0] rop(input logic [5:0] funct);
        return (funct == 6'h22) ? 3'd1 : (funct == 6'h2A) ? 3'd3 : 3'd0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int s;
        r = $urandom;
        s = $urandom_range(0, 13);
        case (s)
            0:  r[31:26] = 6'h23;
            1:  r[31:26] = 6'h2B;
            2:  r[31:26] = 6'h02;
            3:  r[31:26] = 6'h03;
            4:  r[31:26] = 6'h04;
            5:  r[31:26] = 6'h05;
            6:  r[31:26] = 6'h0E;
            7:  r[31:26] = 6'h08;
            8:  begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
            9:  begin r[31:26] = 6'h00; r[5:0] = 6'h20; end
            10: begin r[31:26] = 6'h00; r[5:0] = 6'h22; end
            11: begin r[31:26] = 6'h00; r[5:0] = 6'h2A; end
            12: ;
            default: r[31:26] = 6'h00;
        endcase
        return r;
    endfunction

    function automatic int rand_wait();
        if ($urandom_range(0, 19) == 0) return int'($urandom_range(T - 1, T));
        return int'($urandom_range(0, 2));
    endfunction

    // One clock: drive inputs, queue what the DUT must show during this cycle.
    task automatic cyc(input bit rst, input bit mr, input bit az, input ctrl_t c, input bit chk);
        exp_t e;
        reset         = rst;
        bus.mem_ready = mr;
        bus.alu_zero  = az;
        e.c   = c;
        e.chk = chk;
        e.ill = m_ill;
        e.be  = m_be;
        e.ret = m_ret;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, rb(), rb(), IDLE, 1'b0);
        m_ill = 1'b0;
        m_be  = 1'b0;
        m_ret = '0;
    endtask

    task automatic trap_tail();
        repeat (3) cyc(1'b0, rb(), rb(), IDLE, 1'b1);
        do_reset();
    endtask

    // w not-ready cycles then a ready one; T consecutive not-ready cycles trap.
    task automatic mem_phase(input int w, input ctrl_t c_wait, input ctrl_t c_done,
                             output bit trapped);
        trapped = 1'b0;
        for (int i = 0; i < w; i++) begin
            cyc(1'b0, 1'b0, rb(), c_wait, 1'b1);
            if (i == T - 1) begin
                m_be    = 1'b1;
                trapped = 1'b1;
                return;
            end
        end
        cyc(1'b0, 1'b1, rb(), c_done, 1'b1);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input bit az);
        kind_e k;
        bit    tr;
        ctrl_t c;
        k = kind_of(ins);
        bus.instr = ins;
        mem_phase(fw, mk(0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 3'd0),
                  mk(1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 3'd0), tr);
        if (tr) begin
            trap_tail();
            return;
        end
        cyc(1'b0, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd3, 3'd0), 1'b1);
        case (k)
            KIll: begin
                m_ill = 1'b1;
                trap_tail();
            end
            KLw, KSw: begin
                cyc(1'b0, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd2, 3'd0), 1'b1);
                if (k == KLw) c = mk(0, 0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
                else          c = mk(0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
                mem_phase(mw, c, c, tr);
                if (tr) begin
                    trap_tail();
                    return;
                end
                if (k == KLw) begin
                    cyc(1'b0, rb(), rb(),
                        mk(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0, 3'd0), 1'b1);
                end
                m_ret++;
            end
            KR, KI: begin
                if (k == KR)
                    c = mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, rop(ins[5:0]));
                else
                    c = mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd2,
                           (ins[31:26] == 6'h0E) ? 3'd2 : 3'd0);
                cyc(1'b0, rb(), rb(), c, 1'b1);
                cyc(1'b0, rb(), rb(), mk(0, 0, 0, 0, 1, 0, 0, 2'd0,
                    (k == KR) ? 2'd1 : 2'd0, 2'd0, 2'd0, 3'd0), 1'b1);
                m_ret++;
            end
            KBeq, KBne: begin
                cyc(1'b0, rb(), az, mk((k == KBeq) ? az : !az, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0,
                    2'd0, 2'd0, 3'd1), 1'b1);
                m_ret++;
            end
            default: begin
                cyc(1'b0, rb(), rb(), mk(1, 0, 0, 0, k == KJal, 0, 0,
                    (k == KJr) ? 2'd3 : 2'd2, (k == KJal) ? 2'd2 : 2'd0,
                    (k == KJal) ? 2'd2 : 2'd0, 2'd0, 3'd0), 1'b1);
                m_ret++;
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
                 bus.iord, bus.alu_src_a, bus.pc_src, bus.reg_dst, bus.mem_to_reg,
                 bus.alu_src_b, bus.alu_op} !== mon_e.c) begin
                errors++;
                $display("FAIL ctrl t=%0t got %h exp %h", $time,
                         {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
                          bus.reg_write, bus.iord, bus.alu_src_a, bus.pc_src, bus.reg_dst,
                          bus.mem_to_reg, bus.alu_src_b, bus.alu_op}, mon_e.c);
            end
            if (mon_e.chk) begin
                checks++;
                if ({bus.illegal, bus.bus_error, bus.retired} !== {mon_e.ill, mon_e.be, mon_e.ret})
                begin
                    errors++;
                    $display("FAIL flags t=%0t got ill=%b be=%b ret=%0d exp ill=%b be=%b ret=%0d",
                             $time, bus.illegal, bus.bus_error, bus.retired,
                             mon_e.ill, mon_e.be, mon_e.ret);
                end
            end
        end
    end

    initial begin
        bus.instr     = '0;
        bus.mem_ready = 1'b0;
        bus.alu_zero  = 1'b0;
        m_ill = 1'b0;
        m_be  = 1'b0;
        m_ret = '0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(32'h0022_1820, 0, 0, 1'b0);   // ADD r3,r1,r2
        run_instr(32'h8C22_0004, 0, 3, 1'b0);   // LW, three not-ready cycles
        run_instr(32'h1422_0003, 0, 0, 1'b1);   // BNE, zero set: not taken
        run_instr(32'h1422_0003, 0, 0, 1'b0);   // BNE taken
        run_instr(32'h1022_0003, 0, 0, 1'b1);   // BEQ taken
        run_instr(32'h0C00_0010, 0, 0, 1'b0);   // JAL
        run_instr(32'h03E0_0008, 0, 0, 1'b0);   // JR
        run_instr(32'hAC22_0008, 1, 2, 1'b0);   // SW
        run_instr(32'h3822_00FF, 0, 0, 1'b0);   // XORI
        run_instr(32'h2022_0005, 0, 0, 1'b0);   // ADDI
        run_instr(32'h0022_182A, 0, 0, 1'b0);   // SLT
        run_instr(32'hFC00_0000, 0, 0, 1'b0);   // opcode 0x3F traps
        run_instr(32'h0022_1822, T - 1, 0, 1'b0); // ready on the last allowed cycle
        run_instr(32'h0022_1820, T, 0, 1'b0);   // fetch timeout
        run_instr(32'h0800_0001, 0, 0, 1'b0);   // J
        run_instr(32'h8C22_0004, 0, T, 1'b0);   // read timeout
        run_instr(32'hAC22_0008, 0, T - 1, 1'b0);

        // Reset lands on what would be the WB_ALU cycle: no write may happen.
        bus.instr = 32'h0022_1820;
        cyc(1'b0, 1'b1, 1'b0, mk(1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 3'd0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd3, 3'd0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0), 1'b1);
        do_reset();

        repeat (200) run_instr(rand_instr(), rand_wait(), rand_wait(), rb());

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
